// File: rtl/enc_pkg.sv
// Shared definitions for the instruction-memory loader encoder:
// ImmSrc format codes, FSM state encoding, register field positions,
// and an immediate range helper used when ENC_RANGE_CHECK_EN is defined.
package enc_pkg;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_B = 3'b001;
    localparam logic [2:0] IMM_S = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;
    localparam logic [2:0] IMM_R = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } enc_state_t;

    localparam int RD_LSB     = 7;
    localparam int FUNCT3_LSB = 12;
    localparam int RS1_LSB    = 15;
    localparam int RS2_LSB    = 20;

    // True when v is the sign extension of its low n bits.
    function automatic logic fits_signed(input logic [31:0] v, input int unsigned n);
        logic [31:0] s;
        s = 32'($signed(v) >>> (n - 1));
        return (s == '0) || (s == '1);
    endfunction

endpackage

// File: rtl/imm_pack.sv
// Combinational fields-to-word packer; the inverse of the immediate
// extender's field mapping. With ENC_RANGE_CHECK_EN defined it also flags
// immediates that the extender could not reproduce; otherwise the flag is 0
// and immediates are truncated to their fields.
module imm_pack
    import enc_pkg::*;
(
    input  logic [2:0]  imm_src,
    input  logic [31:0] imm,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    output logic [31:0] word,
    output logic        range_err
);

    // Place opcode, registers and immediate slices according to the format
    always_comb begin
        word = '0;
        word[6:0] = opcode;
        case (imm_src)
            IMM_I: begin
                word[31:20]               = imm[11:0];
                word[RS1_LSB +: 5]        = rs1;
                word[FUNCT3_LSB +: 3]     = funct3;
                word[RD_LSB +: 5]         = rd;
            end
            IMM_S: begin
                word[31:25]               = imm[11:5];
                word[RS2_LSB +: 5]        = rs2;
                word[RS1_LSB +: 5]        = rs1;
                word[FUNCT3_LSB +: 3]     = funct3;
                word[11:7]                = imm[4:0];
            end
            IMM_B: begin
                word[31]                  = imm[12];
                word[30:25]               = imm[10:5];
                word[RS2_LSB +: 5]        = rs2;
                word[RS1_LSB +: 5]        = rs1;
                word[FUNCT3_LSB +: 3]     = funct3;
                word[11:8]                = imm[4:1];
                word[7]                   = imm[11];
            end
            IMM_J: begin
                word[31]                  = imm[20];
                word[30:21]               = imm[10:1];
                word[20]                  = imm[11];
                word[19:12]               = imm[19:12];
                word[RD_LSB +: 5]         = rd;
            end
            IMM_U: begin
                word[31:12]               = imm[31:12];
                word[RD_LSB +: 5]         = rd;
            end
            IMM_R: begin
                word[31:25]               = funct7;
                word[RS2_LSB +: 5]        = rs2;
                word[RS1_LSB +: 5]        = rs1;
                word[FUNCT3_LSB +: 3]     = funct3;
                word[RD_LSB +: 5]         = rd;
            end
            default: ;
        endcase
    end

`ifdef ENC_RANGE_CHECK_EN
    // Reject immediates that would not survive a round trip through the extender
    always_comb begin
        range_err = 1'b0;
        case (imm_src)
            IMM_I, IMM_S: range_err = !fits_signed(imm, 12);
            IMM_B:        range_err = !fits_signed(imm, 13) || imm[0];
            IMM_J:        range_err = !fits_signed(imm, 21) || imm[0];
            IMM_U:        range_err = (imm[11:0] != 12'd0);
            IMM_R:        range_err = 1'b0;
            default:      range_err = 1'b1;
        endcase
    end
`else
    assign range_err = 1'b0;
`endif

endmodule

// File: rtl/inst_encoder.sv
// Streaming instruction encoder feeding the instruction-memory loader.
// Optional feature macro: ENC_RANGE_CHECK_EN (drop out-of-range words, sticky err).
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | waiting for start; base address latched on start
// ST_RUN  | accepting words and writing them to consecutive addresses
// ST_DONE | one-cycle session end, done asserted
module inst_encoder
    import enc_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 32
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [2:0]        imm_src,
    input  logic [31:0]       imm,
    input  logic [6:0]        opcode,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    output logic              wr_en,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              done,
    output logic [8:0]        count,
    output logic              err
);

    enc_state_t  state;
    logic        last_taken;
    logic [31:0] packed_word;
    logic        range_err;
    logic        wr_fire;
    logic        accept;
    logic        final_word;
    logic [9:0]  word_num;

    imm_pack u_pack (
        .imm_src   (imm_src),
        .imm       (imm),
        .opcode    (opcode),
        .rd        (rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .funct3    (funct3),
        .funct7    (funct7),
        .word      (packed_word),
        .range_err (range_err)
    );

    assign wr_fire  = wr_en && wr_ready;
    assign in_ready = (state == ST_RUN) && (!wr_en || wr_ready) && !last_taken;
    assign accept   = in_valid && in_ready;

    // Any pending word completes in the accept cycle, so the new word's ordinal
    // is the completed count plus the pending word plus one.
    assign word_num   = {1'b0, count} + {9'd0, wr_en} + 10'd1;
    assign final_word = in_last || (!range_err && (word_num == 10'(DEPTH)));

`ifdef ENC_RANGE_CHECK_EN
    logic err_q;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // Session FSM with the output register, address and count bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            count      <= '0;
            done       <= 1'b0;
            last_taken <= 1'b0;
`ifdef ENC_RANGE_CHECK_EN
            err_q      <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state      <= ST_RUN;
                        wr_addr    <= base_addr & ~(ADDR_W'(3));
                        count      <= '0;
                        wr_en      <= 1'b0;
                        last_taken <= 1'b0;
`ifdef ENC_RANGE_CHECK_EN
                        err_q      <= 1'b0;
`endif
                    end
                end
                ST_RUN: begin
                    if (wr_fire) begin
                        wr_addr <= wr_addr + ADDR_W'(4);
                        count   <= count + 9'd1;
                    end
                    if (accept && !range_err) begin
                        wr_en   <= 1'b1;
                        wr_data <= packed_word;
                    end else if (wr_fire) begin
                        wr_en <= 1'b0;
                    end
                    if (accept && final_word) begin
                        last_taken <= 1'b1;
                    end
`ifdef ENC_RANGE_CHECK_EN
                    if (accept && range_err) begin
                        err_q <= 1'b1;
                    end
`endif
                    // A dropped final word ends the session without a write
                    if ((wr_fire && last_taken) || (accept && range_err && in_last)) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state      <= ST_IDLE;
                    last_taken <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/inst_encoder.md
# inst_encoder

Streaming RISC-V instruction encoder for the multicycle processor's instruction-memory loader. It accepts decoded fields (opcode, registers, funct, full 32-bit immediate, `ImmSrc` format code) over a valid/ready handshake. It packs them into 32-bit instruction words, which are the exact inverse of the immediate extender's field mapping. It writes those words to consecutive word addresses of instruction memory through a back-pressured write port.

## Interface
- `DEPTH`, 256: maximum words per load session.
- `ADDR_W`, 32: width of the write address.
- `clk` in 1: the only clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: begin a session. Sampled only in IDLE.
- `base_addr` in ADDR_W: first write address. Latched on `start`; bits [1:0] forced to 0.
- `in_valid` in 1, `in_ready` out 1: input handshake.
- `in_last` in 1: marks the final word of the session.
- `imm_src` in 3: format code. 000 I, 001 B, 010 S, 011 J, 100 U, 101 R; 110 and 111 are invalid.
- `imm` in 32: the immediate as the extender would output it.
- `opcode` in 7; `rd`, `rs1`, `rs2` in 5; `funct3` in 3; `funct7` in 7: instruction fields.
- `wr_en` out 1, `wr_ready` in 1, `wr_addr` out ADDR_W, `wr_data` out 32: memory write port.
- `done` out 1: one-cycle pulse at session end.
- `count` out 9: number of words written this session.
- `err` out 1: sticky range error. Exists only with `ENC_RANGE_CHECK_EN`; otherwise tied to 0.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN on `start`: latch `base_addr`, clear `count`, clear `err`.
  - RUN → DONE when the write of a word accepted with `in_last` completes (`wr_en && wr_ready`).
  - RUN → DONE when the write of word number `DEPTH` completes, regardless of `in_last`.
  - DONE → IDLE unconditionally; `done`=1 only while in DONE.
  - `start` outside IDLE is ignored.
- Input accept: `in_ready` = RUN && (!`wr_en` || `wr_ready`) && no final word accepted yet. An accept occurs when `in_valid && in_ready`.
- The packed word is held in a single output register, so `wr_en`/`wr_addr`/`wr_data` are stable until `wr_ready`.
- After each completed write: `wr_addr` += 4 (wraps modulo 2^ADDR_W) and `count` += 1.
- Every format places `opcode` in [6:0].
- Field placement by format:
  - I: [31:20]=imm[11:0], rs1, funct3, rd.
  - S: [31:25]=imm[11:5], rs2, rs1, funct3, [11:7]=imm[4:0].
  - B: [31]=imm[12], [30:25]=imm[10:5], rs2, rs1, funct3, [11:8]=imm[4:1], [7]=imm[11].
  - J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12], rd.
  - U: [31:12]=imm[31:12], rd.
  - R: [31:25]=funct7, rs2, rs1, funct3, rd.
- Register bit positions: rd [11:7], funct3 [14:12], rs1 [19:15], rs2 [24:20].
- Fields a format does not use are ignored.

## Timing
- Latency: one cycle from accept to `wr_en`=1.
- Throughput: one word per cycle while `wr_ready`=1.
- Reset values: state IDLE, `wr_en` 0, `wr_addr` 0, `wr_data` 0, `count` 0, `done` 0, `err` 0, `in_ready` 0.
- Reset mid-session aborts immediately. A pending word is discarded and nothing further is written.
- Accept and write-completion in the same cycle: the output register reloads with the new word and the address advances once.
- `in_last` on word number `DEPTH` is equivalent to the cap.

## Configuration
- `ENC_RANGE_CHECK_EN` defined: an accepted word is out of range when any of these holds:
  - I/S: imm is not a sign-extended 12-bit value.
  - B: imm is not sign-extended 13-bit, or imm[0]=1.
  - J: imm is not sign-extended 21-bit, or imm[0]=1.
  - U: imm[11:0]≠0.
  - `imm_src` is invalid.
- An out-of-range word is not written and does not advance `count`. It sets `err`, which stays set until `start` or `reset`. If that word carried `in_last`, the session still ends, with DONE one cycle after the accept.
- Not defined: no checks. Immediates are silently truncated to their fields. An invalid `imm_src` emits `{25'b0, opcode}`.

## Structure
- Package `enc_pkg`: `ImmSrc` encoding constants (`IMM_I` … `IMM_R`), the FSM state enum, and the bit-position constants for rd, funct3, rs1 and rs2.
- Sub-module `imm_pack`: purely combinational fields-to-word packer, which also produces the range-error flag. It is unit-tested separately against the extender for round-trip equality.
- `inst_encoder` contains the FSM, handshake, output register and counters.

## Test plan
- I-type: `imm_src` 000, imm 0xFFFFFFFF, opcode 0x13, rd 1, rs1 0, funct3 0 → `wr_data` 0xFFF00093 at `base_addr` 0x100.
- Stream of S, B, J, U words, `wr_ready` held at 1:
  - S: opcode 0x23, funct3 2, rs1 1, rs2 2, imm 4 → 0x0020A223.
  - B: opcode 0x63, rs1 0, rs2 0, imm 8 → 0x00000463.
  - J: opcode 0x6F, rd 1, imm 0x800 → 0x001000EF.
  - U: opcode 0x37, rd 5, imm 0x12345000 → 0x123452B7.
  - Required: addresses +4 each, `count` 4, one `done` pulse after the `in_last` word.
- Back-pressure: hold `wr_ready`=0 for 3 cycles → `wr_data`/`wr_addr` stable, `in_ready` 0, no word lost or duplicated.
- Cap: `DEPTH`=4 with 6 valid words and no `in_last` → exactly 4 writes, then DONE; `in_ready` 0 thereafter.
- Range check (macro on): B-type with imm 0x1001 → no write, `err`=1; the next valid word is still written at the unadvanced address.
- Reset while a word is pending → all outputs return to reset values the next cycle; no write occurs.
